// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply and
// restoring divide. Optional define MULDIV_EARLY_TERM_EN ends a multiply once the multiplier is exhausted.
module pipe_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e             state_q;
  logic               is_div_q, dz_q, neg_q_q, neg_r_q, done_q, dbz_q;
  logic [CntW-1:0]    cnt_q;
  // Multiply: acc = product, sh = shifted multiplicand, q = remaining multiplier.
  // Divide: acc[WIDTH-1:0] = partial remainder, sh[WIDTH-1:0] = divisor, q = dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, sh_q;
  logic [WIDTH-1:0]   q_q, hi_q, lo_q;

  logic               neg_a, neg_b, ge, last_iter;
  logic [WIDTH-1:0]   abs_a, abs_b, rem_sub, quo_fix, rem_fix;
  logic [WIDTH:0]     cur;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    neg_a     = ~op_i[0] & a_i[WIDTH-1];
    neg_b     = ~op_i[0] & b_i[WIDTH-1];
    abs_a     = neg_a ? -a_i : a_i;
    abs_b     = neg_b ? -b_i : b_i;
    cur       = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge        = cur >= {1'b0, sh_q[WIDTH-1:0]};
    rem_sub   = cur[WIDTH-1:0] - sh_q[WIDTH-1:0];
    last_iter = (cnt_q == CntW'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
    if (!is_div_q && ((q_q >> 1) == '0)) last_iter = 1'b1;
`else
`endif
    prod_fix  = neg_q_q ? -acc_q : acc_q;
    quo_fix   = neg_q_q ? -q_q : q_q;
    rem_fix   = neg_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      q_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_hi_i) hi_q <= wr_data_i;
          if (wr_lo_i) lo_q <= wr_data_i;
          if (start_i && !flush_i) begin
            is_div_q <= op_i[1];
            cnt_q    <= '0;
            neg_q_q  <= neg_a ^ neg_b;
            neg_r_q  <= neg_a;
            dz_q     <= op_i[1] && (b_i == '0);
            if (op_i[1]) begin
              sh_q <= {{WIDTH{1'b0}}, abs_b};
              q_q  <= abs_a;
              if (b_i == '0) begin
                // Keep the raw dividend; it becomes HI on divide-by-zero.
                acc_q   <= {{WIDTH{1'b0}}, a_i};
                state_q <= StFix;
              end else begin
                acc_q   <= '0;
                state_q <= StIter;
              end
            end else begin
              acc_q   <= '0;
              sh_q    <= {{WIDTH{1'b0}}, abs_a};
              q_q     <= abs_b;
              state_q <= StIter;
            end
          end
        end
        StIter: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else begin
            if (is_div_q) begin
              acc_q[WIDTH-1:0] <= ge ? rem_sub : cur[WIDTH-1:0];
              q_q              <= {q_q[WIDTH-2:0], ge};
            end else begin
              acc_q <= acc_q + (q_q[0] ? sh_q : '0);
              sh_q  <= sh_q << 1;
              q_q   <= q_q >> 1;
            end
            cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
            if (last_iter) state_q <= StFix;
          end
        end
        StFix: begin
          if (!flush_i) begin
            done_q <= 1'b1;
            dbz_q  <= dz_q;
            if (dz_q) begin
              hi_q <= acc_q[WIDTH-1:0];
              lo_q <= '1;
            end else if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_pipe_muldiv.sv
// Self-checking bench for pipe_muldiv: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for flush, reset and back-to-back starts.
module tb_pipe_muldiv;
  localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, flush, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wr_data;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  pipe_muldiv #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .op_i         (op),
    .a_i          (a),
    .b_i          (b),
    .flush_i      (flush),
    .wr_hi_i      (wr_hi),
    .wr_lo_i      (wr_lo),
    .wr_data_i    (wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .div_by_zero_o(dbz),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values, MIPS semantics for the corner cases.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic ez, output int lat);
    logic signed [63:0] sx, sy, sp;
    logic [63:0]        up;
    logic signed [31:0] dx, dy;
    logic [31:0]        mag;
    ez  = 1'b0;
    lat = 33;
    eh  = '0;
    el  = '0;
    if (o == 2'd0) begin
      sx = $signed(x);
      sy = $signed(y);
      sp = sx * sy;
      {eh, el} = sp;
    end else if (o == 2'd1) begin
      up = {32'b0, x} * {32'b0, y};
      {eh, el} = up;
    end else if (y == 0) begin
      eh = x; el = '1; ez = 1'b1; lat = 1;
    end else if (o == 2'd2) begin
      if (x == 32'h8000_0000 && y == 32'hffff_ffff) begin
        el = x; eh = '0;
      end else begin
        dx = x; dy = y;
        el = dx / dy;
        eh = dx % dy;
      end
    end else begin
      el = x / y;
      eh = x % y;
    end
    if (ET && !o[1]) begin
      mag = (o == 2'd0 && y[31]) ? -y : y;
      lat = 2;
      for (int i = 1; i < 32; i++) if ((mag >> i) != 0) lat = i + 2;
    end
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                           input logic ez, input int elat);
    int n;
    launch(o, x, y);
    chk({nm, "_busy"}, busy, 1);
    wait_done(n);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_dz"}, dbz, ez);
    chk({nm, "_idle"}, busy, 0);
    @(posedge clk);
    #1 chk({nm, "_pulse"}, {done, dbz}, 0);
  endtask

  initial begin
    vec_t        tv[10];
    logic [1:0]  ro;
    logic [31:0] rx, ry, eh, el;
    logic        ez;
    int          lat, n, seen;

    tv[0] = '{2'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffff, 32'hffff_ffeb, 1'b0, ET ? 3 : 33};
    tv[1] = '{2'd1, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h1, 1'b0, 33};
    tv[2] = '{2'd2, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0, 33};
    tv[3] = '{2'd2, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 1'b0, 33};
    tv[4] = '{2'd3, 32'd100, 32'd0, 32'h64, 32'hffff_ffff, 1'b1, 1};
    tv[5] = '{2'd2, 32'hffff_fffb, 32'd0, 32'hffff_fffb, 32'hffff_ffff, 1'b1, 1};
    tv[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33};
    tv[7] = '{2'd3, 32'hffff_ffff, 32'd16, 32'hf, 32'h0fff_ffff, 1'b0, 33};
    tv[8] = '{2'd2, 32'd7, 32'hffff_fffe, 32'h1, 32'hffff_fffd, 1'b0, 33};
    tv[9] = '{2'd1, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, ET ? 2 : 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; a = '0; b = '0; wr_data = '0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dbz, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo,
                tv[i].dz, tv[i].lat);

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) ry = '0;
      model(ro, rx, ry, eh, el, ez, lat);
      run_check($sformatf("rnd%0d", i), ro, rx, ry, eh, el, ez, lat);
    end

    // Preload HI/LO, then abort a multiply mid-flight.
    @(negedge clk); wr_hi = 1'b1; wr_data = 32'h1234;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
    @(negedge clk); wr_lo = 1'b0;
    chk("pre_hi", hi, 32'h1234);
    chk("pre_lo", lo, 32'h5678);
    launch(2'd0, 32'd7, 32'h4000_0003);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1; start = 1'b1; op = 2'd2; a = 32'd50; b = 32'd5;
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h5678);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) seen++;
    end
    chk("flush_quiet", seen, 0);
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush_start_drop", busy, 0);
    model(2'd1, 32'h0001_2345, 32'h777, eh, el, ez, lat);
    run_check("after_flush", 2'd1, 32'h0001_2345, 32'h777, eh, el, ez, lat);

    // Reset in the middle of a divide.
    launch(2'd2, 32'hffff_fff9, 32'd2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    launch(2'd3, 32'd1000, 32'd7);
    chk("post_rst_busy", busy, 1);
    @(negedge clk); wr_hi = 1'b1; wr_data = 32'hdead_beef;
    @(posedge clk);
    #1 wr_hi = 1'b0;
    chk("busy_wr_hi", hi, 0);
    wait_done(n);
    chk("post_rst_lat", n + 1, 33);
    chk("post_rst_hi", hi, 32'd6);
    chk("post_rst_lo", lo, 32'd142);

    // New start accepted in the cycle done is high.
    launch(2'd3, 32'd100, 32'd0);
    wait_done(n);
    chk("b2b_dz_lat", n, 1);
    chk("b2b_dz_flag", dbz, 1);
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'hffff_ffff; b = 32'hffff_ffff;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_pulse", {done, dbz}, 0);
    wait_done(n);
    chk("b2b_lat", n, 33);
    chk("b2b_hi", hi, 32'hffff_fffe);
    chk("b2b_lo", lo, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
